vector_frame_reader: RTL and testbench
======================================

Name: vector_frame_reader

Overview:
Read side of the vector frame RAM. The frame builder writes vector words into RAM; this block scans them from address 0, decodes each word into an X/Y DAC coordinate plus a beam-blank flag, and holds each point for a fixed dwell time. At end of frame it pulses frame_done, which the frame builder uses as its go/restart strobe. It sits between the frame RAM read port and the X/Y DAC drivers.

Parameters:
ADR_WIDTH, 10, RAM address width.
DATAWIDTH, 18, RAM word width; must be at least 2*OUT_WIDTH+2.
OUT_WIDTH, 8, width of each DAC coordinate.
DEPTH, 1024, number of frame words scanned before a forced end of frame; must be at most 2^ADR_WIDTH.
DWELL_CYCLES, 16, number of cycles each point is held; must be at least 1.
SETTLE_CYCLES, 4, number of blank settle cycles (optional feature only); must be less than DWELL_CYCLES.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
enable  in  1  1 = scan frames continuously; sampled only in IDLE and FRAME_END.
halt  in  1  1 = freeze the whole block: state, address, counters and outputs.
adrREAD  out  ADR_WIDTH  RAM read address (registered).
dataREAD  in  DATAWIDTH  RAM read data; valid one cycle after adrREAD (synchronous RAM).
xout  out  OUT_WIDTH  X DAC code (registered).
yout  out  OUT_WIDTH  Y DAC code (registered).
blank  out  1  1 = beam off.
frame_done  out  1  single-cycle pulse at the end of each frame.

Behaviour:
- Word format: bit [2*OUT_WIDTH+1] = EOF; bit [2*OUT_WIDTH] = draw (1 = beam on); bits [2*OUT_WIDTH-1:OUT_WIDTH] = x; bits [OUT_WIDTH-1:0] = y. Bits above these are ignored.
- Reset (rst=0, asynchronous): state IDLE, adrREAD=0, xout=0, yout=0, blank=1, frame_done=0, dwell counter=0.
- IDLE: blank=1, adrREAD=0. If enable=1, go to FETCH.
- FETCH (1 cycle): the RAM samples adrREAD. Go to LATCH.
- LATCH (1 cycle): decode dataREAD.
  - EOF=1: go to FRAME_END; xout and yout are unchanged.
  - Otherwise: xout<=x, yout<=y, blank<=~draw, dwell counter<=DWELL_CYCLES-1, go to DWELL.
- DWELL: decrement the counter; outputs hold. When the counter is 0:
  - If adrREAD==DEPTH-1, go to FRAME_END (forced end, no EOF word needed).
  - Otherwise adrREAD<=adrREAD+1 and go to FETCH.
- FRAME_END (1 cycle): frame_done=1, blank<=1, adrREAD<=0. Next state is FETCH if enable=1, else IDLE.
- frame_done is high only in the FRAME_END cycle; at most one pulse per frame.
- Timing per point: DWELL_CYCLES+2 cycles. A frame of N points ending in an EOF word: N*(DWELL_CYCLES+2)+3 cycles between frame_done pulses.
- Startup: with enable=1 in IDLE at edge k, the first point appears on the outputs after edge k+2.
- halt=1: every register holds its value, including frame_done (which is therefore stretched if halt arrives during FRAME_END). adrREAD is held, so RAM data stays valid and LATCH resumes correctly. Each halt cycle extends the frame by exactly one cycle.
- enable dropped mid-frame: the current frame completes normally (frame_done pulses), then the block goes to IDLE.
- Empty frame (word 0 is EOF): frame_done pulses every 3 cycles; blank stays 1.
- Address wrap: adrREAD never exceeds DEPTH-1 and always returns to 0 via FRAME_END.
- Reset mid-frame: outputs return immediately to their reset values; the next frame starts from address 0.

Optional Feature:
- Macro BLANK_SETTLE_EN.
- When defined: in LATCH, if the new x or y differs from the current xout/yout, blank is forced to 1 for the first SETTLE_CYCLES cycles of DWELL. After that, blank becomes ~draw for the rest of the dwell. This avoids drawing streaks while the DAC output slews.
- When undefined: blank<=~draw in LATCH with no settle period. SETTLE_CYCLES is unused.

Test Plan:
- Reset: hold rst=0 for 3 cycles with enable=1 -> adrREAD=0, xout=yout=0, blank=1, frame_done=0 throughout.
- Basic frame: DWELL_CYCLES=4; RAM = (10,20,draw), (30,40,move), (50,60,draw), EOF; enable=1 -> outputs (10,20,blank0), (30,40,blank1), (50,60,blank0), each held 4 cycles; frame_done pulses every 21 cycles; 4 frames complete.
- Halt: assert halt for 10 cycles during the second point's dwell -> xout/yout/blank/adrREAD frozen for those cycles; the frame_done spacing for that frame becomes 31.
- Empty frame: word 0 = EOF -> frame_done every 3 cycles; blank stays 1; adrREAD stays 0.
- Forced end: DEPTH=8 with no EOF in RAM, DWELL_CYCLES=4 -> 8 points shown, adrREAD goes 0..7 and back to 0, frame_done every 49 cycles.
- Enable drop and reset: clear enable during point 1 -> frame finishes, one frame_done pulse, then IDLE with blank=1. Pulse rst=0 mid-dwell -> outputs return to reset values asynchronously, before the next clock edge.
- With BLANK_SETTLE_EN and SETTLE_CYCLES=2 on the basic frame -> blank=1 for the first 2 cycles of each point; draw points then show blank=0 for the remaining 2 cycles.

Source files
------------

// File: rtl/vector_frame_reader.sv
// Vector frame RAM scanner: decodes words into X/Y DAC codes and dwells on each point.
// Optional macro BLANK_SETTLE_EN adds a blank settle window after each beam move.
module vector_frame_reader #(
    parameter int ADR_WIDTH     = 10,
    parameter int DATAWIDTH     = 18,
    parameter int OUT_WIDTH     = 8,
    parameter int DEPTH         = 1024,
    parameter int DWELL_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 halt,
    output logic [ADR_WIDTH-1:0] adrREAD,
    input  logic [DATAWIDTH-1:0] dataREAD,
    output logic [OUT_WIDTH-1:0] xout,
    output logic [OUT_WIDTH-1:0] yout,
    output logic                 blank,
    output logic                 frame_done
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0]        DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [ADR_WIDTH-1:0] ADR_LAST   = ADR_WIDTH'(DEPTH - 1);

    if (DWELL_CYCLES < 1 || SETTLE_CYCLES >= DWELL_CYCLES ||
        DATAWIDTH < 2*OUT_WIDTH+2 || DEPTH > 2**ADR_WIDTH) begin : g_param_check
        $error("vector_frame_reader: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        DWELL,
        FRAME_END
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;

    logic                 w_eof;
    logic                 w_draw;
    logic [OUT_WIDTH-1:0] w_x;
    logic [OUT_WIDTH-1:0] w_y;

    assign w_eof  = dataREAD[2*OUT_WIDTH+1];
    assign w_draw = dataREAD[2*OUT_WIDTH];
    assign w_x    = dataREAD[2*OUT_WIDTH-1:OUT_WIDTH];
    assign w_y    = dataREAD[OUT_WIDTH-1:0];

`ifdef BLANK_SETTLE_EN
    // Dwell count at which the settle window ends and the beam may turn on.
    localparam logic [CW-1:0] SETTLE_END = CW'(DWELL_CYCLES - SETTLE_CYCLES);

    logic settle_q;
    logic draw_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            adrREAD    <= '0;
            xout       <= '0;
            yout       <= '0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            cnt        <= '0;
`ifdef BLANK_SETTLE_EN
            settle_q   <= 1'b0;
            draw_q     <= 1'b0;
`endif
        end else if (!halt) begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    adrREAD <= '0;
                    blank   <= 1'b1;
                    if (enable) state <= FETCH;
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    if (w_eof) begin
                        state      <= FRAME_END;
                        frame_done <= 1'b1;
                    end else begin
                        xout  <= w_x;
                        yout  <= w_y;
                        cnt   <= DWELL_LAST;
                        state <= DWELL;
`ifdef BLANK_SETTLE_EN
                        draw_q <= w_draw;
                        if ((w_x != xout || w_y != yout) &&
                            SETTLE_CYCLES > 0) begin
                            blank    <= 1'b1;
                            settle_q <= 1'b1;
                        end else begin
                            blank    <= ~w_draw;
                            settle_q <= 1'b0;
                        end
`else
                        blank <= ~w_draw;
`endif
                    end
                end
                DWELL: begin
`ifdef BLANK_SETTLE_EN
                    if (settle_q && cnt == SETTLE_END) begin
                        blank    <= ~draw_q;
                        settle_q <= 1'b0;
                    end
`endif
                    if (cnt == '0) begin
                        // Last RAM slot ends the frame even without an EOF word.
                        if (adrREAD == ADR_LAST) begin
                            state      <= FRAME_END;
                            frame_done <= 1'b1;
                        end else begin
                            adrREAD <= adrREAD + 1'b1;
                            state   <= FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FRAME_END: begin
                    blank   <= 1'b1;
                    adrREAD <= '0;
                    state   <= enable ? FETCH : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_frame_reader.sv
// Bench for vector_frame_reader: directed phases, random frame contents,
// per-cycle comparison against a point-list timeline model.
module tb_vector_frame_reader;

    localparam int AW     = 3;
    localparam int DW     = 18;
    localparam int OW     = 8;
    localparam int DEPTH  = 8;
    localparam int DWELL  = 4;
    localparam int SETTLE = 2;
`ifdef BLANK_SETTLE_EN
    localparam bit SETTLE_ON = 1'b1;
`else
    localparam bit SETTLE_ON = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          enable = 1'b0;
    logic          halt   = 1'b0;
    logic [AW-1:0] adrREAD;
    logic [DW-1:0] dataREAD;
    logic [OW-1:0] xout;
    logic [OW-1:0] yout;
    logic          blank;
    logic          frame_done;

    logic [DW-1:0] mem [DEPTH];

    int passed = 0;
    int total  = 0;
    int step   = 0;

    typedef struct {
        int adr;
        int x;
        int y;
        int b;
        int fd;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   mx;
    int   my;
    int   mb;

    vector_frame_reader #(
        .ADR_WIDTH    (AW),
        .DATAWIDTH    (DW),
        .OUT_WIDTH    (OW),
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .halt      (halt),
        .adrREAD   (adrREAD),
        .dataREAD  (dataREAD),
        .xout      (xout),
        .yout      (yout),
        .blank     (blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dataREAD <= mem[adrREAD];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_entry(exp_t e);
        chk($sformatf("adr@%0d", step), 32'(adrREAD), e.adr);
        chk($sformatf("x@%0d", step), 32'(xout), e.x);
        chk($sformatf("y@%0d", step), 32'(yout), e.y);
        chk($sformatf("blank@%0d", step), 32'(blank), e.b);
        chk($sformatf("frame_done@%0d", step), 32'(frame_done), e.fd);
        step++;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_adr"}, 32'(adrREAD), 0);
        chk({tag, "_x"}, 32'(xout), 0);
        chk({tag, "_y"}, 32'(yout), 0);
        chk({tag, "_blank"}, 32'(blank), 1);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) begin
                $display("FAIL model_queue: observed empty, expected entries");
                $fatal(1, "expected timeline exhausted");
            end
            last = q.pop_front();
            check_entry(last);
        end
    endtask

    task automatic hold(int n);
        repeat (n) begin
            @(negedge clk);
            check_entry(last);
        end
    endtask

    function automatic void push(int a, int fd);
        exp_t e;
        e.adr = a;
        e.x   = mx;
        e.y   = my;
        e.b   = mb;
        e.fd  = fd;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        mx = 0;
        my = 0;
        mb = 1;
        q.delete();
    endfunction

    // Each point: fetch + latch cycles showing the old point, then the dwell.
    function automatic void model_frame();
        for (int a = 0; a < DEPTH; a++) begin
            logic [DW-1:0] w;
            int nx;
            int ny;
            int draw;
            bit moved;
            w = mem[a];
            push(a, 0);
            push(a, 0);
            if (w[2*OW+1]) begin
                push(a, 1);
                mb = 1;
                return;
            end
            nx    = int'(w[2*OW-1:OW]);
            ny    = int'(w[OW-1:0]);
            draw  = int'(w[2*OW]);
            moved = (nx != mx) || (ny != my);
            mx    = nx;
            my    = ny;
            for (int d = 0; d < DWELL; d++) begin
                mb = (SETTLE_ON && moved && d < SETTLE) ? 1 : 1 - draw;
                push(a, 0);
            end
            if (a == DEPTH - 1) begin
                push(a, 1);
                mb = 1;
                return;
            end
        end
    endfunction

    function automatic void model_idle(int n);
        mb = 1;
        repeat (n) push(0, 0);
    endfunction

    task automatic load_basic();
        mem[0] = {2'b01, 8'd10, 8'd20};
        mem[1] = {2'b00, 8'd30, 8'd40};
        mem[2] = {2'b01, 8'd50, 8'd60};
        mem[3] = {2'b10, 16'h0000};
        for (int i = 4; i < DEPTH; i++) mem[i] = {1'b0, 17'($urandom)};
    endtask

    int eofpos;
    int nfr;
    int len;

    initial begin
        load_basic();
        enable = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset($sformatf("reset%0d", i));
        end
        rst = 1'b0;

        // Basic frame, four frames back to back, halt in frame 2 point 1.
        for (int f = 0; f < 5; f++) model_frame();
        model_idle(4);
        rst = 1'b1;
        run(21);
        run(9);
        halt = 1'b1;
        hold(10);
        halt = 1'b0;
        run(12);
        run(42);
        // Enable dropped during point 1 of frame 5.
        run(9);
        enable = 1'b0;
        run(16);

        // Empty frame, forced end, then random frames.
        for (int it = 0; it < 6; it++) begin
            eofpos = (it == 0) ? 0 :
                     (it == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
            nfr = (it == 0) ? 3 : 2;
            for (int i = 0; i < DEPTH; i++)
                mem[i] = (i == eofpos) ? {2'b10, 16'($urandom)}
                                       : {1'b0, 17'($urandom)};
            for (int f = 0; f < nfr - 1; f++) model_frame();
            len = q.size();
            model_frame();
            model_idle(3);
            enable = 1'b1;
            run(len + 1);
            enable = 1'b0;
            run(q.size());
        end

        // Asynchronous reset in the middle of a dwell.
        load_basic();
        enable = 1'b1;
        model_frame();
        run(10);
        #2 rst = 1'b0;
        #1 chk_reset("async_rst");
        model_reset();
        @(negedge clk);
        chk_reset("async_rst_hold");
        rst = 1'b1;
        model_frame();
        model_idle(3);
        run(1);
        enable = 1'b0;
        run(q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
